// File: rtl/conv_encoder_stream.sv
// Streaming rate-1/2 convolutional encoder with K-1 zero tail bits, one coded bit per handshake.
// Optional macro PUNCTURE_EN: rate-2/3 puncturing (g1 dropped on odd steps).
module conv_encoder_stream #(
  parameter int             MSG_SIZE = 6,
  parameter int             K        = 2,
  parameter logic [K-1:0]   G0       = 2'b01,
  parameter logic [K-1:0]   G1       = 2'b11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MSG_SIZE-1:0] in_msg,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_bit,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int S  = MSG_SIZE + K - 1;
  localparam int SW = $clog2(S + 1);

`ifdef PUNCTURE_EN
  localparam bit PUNCT = 1'b1;
`else
  localparam bit PUNCT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ENCODE, FLUSH} state_t;

  state_t              state_reg, state_next;
  logic [MSG_SIZE-1:0] msg_reg, msg_next;
  logic [K-2:0]        mem_reg, mem_next;
  logic [SW-1:0]       step_reg, step_next;
  logic                phase_reg, phase_next;

  logic [MSG_SIZE-1:0] bit_sel;
  logic                cur_bit;
  logic [K-1:0]        window;
  logic                g0_bit, g1_bit;
  logic                skip_g1, step_end, last_step;

  // One-hot select of the payload bit for the current step; zero outside ENCODE
  // so FLUSH steps feed the tail zeros.
  genvar gi;
  generate
    for (gi = 0; gi < MSG_SIZE; gi++) begin : g_sel
      assign bit_sel[gi] = (step_reg == SW'(gi)) & msg_reg[gi];
    end
  endgenerate

  assign cur_bit   = (state_reg == ENCODE) & (|bit_sel);
  assign window    = {mem_reg, cur_bit};
  assign g0_bit    = ^(window & G0);
  assign g1_bit    = ^(window & G1);
  assign skip_g1   = PUNCT & step_reg[0];
  assign step_end  = phase_reg | skip_g1;
  assign last_step = (step_reg == SW'(S - 1));

  // All outputs derive from registered state only.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg != IDLE);
  assign out_bit   = out_valid & (phase_reg ? g1_bit : g0_bit);
  assign out_last  = out_valid & step_end & last_step;

  always_comb begin
    state_next = state_reg;
    msg_next   = msg_reg;
    mem_next   = mem_reg;
    step_next  = step_reg;
    phase_next = phase_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          msg_next   = in_msg;
          mem_next   = '0;
          step_next  = '0;
          phase_next = 1'b0;
          state_next = ENCODE;
        end
      end
      ENCODE, FLUSH: begin
        if (out_ready) begin
          if (!step_end) begin
            phase_next = 1'b1;
          end else begin
            phase_next = 1'b0;
            mem_next   = window[K-2:0];
            step_next  = step_reg + SW'(1);
            if (last_step)
              state_next = IDLE;
            else if (step_reg == SW'(MSG_SIZE - 1))
              state_next = FLUSH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      msg_reg   <= '0;
      mem_reg   <= '0;
      step_reg  <= '0;
      phase_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      msg_reg   <= msg_next;
      mem_reg   <= mem_next;
      step_reg  <= step_next;
      phase_reg <= phase_next;
    end
  end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Scoreboard bench for conv_encoder_stream: default instance plus a K=3 instance.
module tb_conv_encoder_stream;

  logic clk = 1'b0;
  logic rst;
  logic out_ready;
  always #5 clk = ~clk;

  logic [5:0] a_in_msg, b_in_msg;
  logic a_in_valid, a_in_ready, a_out_bit, a_out_valid, a_out_last;
  logic b_in_valid, b_in_ready, b_out_bit, b_out_valid, b_out_last;

  conv_encoder_stream dut_a (
    .clk(clk), .rst(rst), .in_msg(a_in_msg), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_bit(a_out_bit), .out_valid(a_out_valid), .out_ready(out_ready), .out_last(a_out_last)
  );

  conv_encoder_stream #(.MSG_SIZE(6), .K(3), .G0(3'b111), .G1(3'b101)) dut_b (
    .clk(clk), .rst(rst), .in_msg(b_in_msg), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_bit(b_out_bit), .out_valid(b_out_valid), .out_ready(out_ready), .out_last(b_out_last)
  );

  typedef struct {
    bit b;
    bit last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops_a = 0;
  int   pops_b = 0;

  // Hand-computed coded streams, first bit leftmost.
`ifdef PUNCTURE_EN
  string a_one  = "11000000000";
  string a_ones = "11110110101";
  string b_one  = "111110000000";
`else
  string a_one  = "11010000000000";
  string a_ones = "11101010101001";
  string b_one  = "1110110000000000";
`endif

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, req);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 1) ? qb.size() : qa.size();
  endfunction

  task automatic push_exp(input int sel, input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.b    = (s.getc(i) == 8'd49);
      e.last = (i == s.len() - 1);
      if (sel == 1) qb.push_back(e);
      else          qa.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && a_out_valid && out_ready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_extra: got bit %0b, expected no output", a_out_bit);
        end else begin
          e = qa.pop_front();
          check($sformatf("a_bit%0d", pops_a), a_out_bit, e.b);
          check($sformatf("a_last%0d", pops_a), a_out_last, e.last);
        end
        pops_a++;
        $display("a bit %0d: out_bit=%0b out_last=%0b", pops_a, a_out_bit, a_out_last);
      end
      if (!rst && b_out_valid && out_ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra: got bit %0b, expected no output", b_out_bit);
        end else begin
          e = qb.pop_front();
          check($sformatf("b_bit%0d", pops_b), b_out_bit, e.b);
          check($sformatf("b_last%0d", pops_b), b_out_last, e.last);
        end
        pops_b++;
        $display("b bit %0d: out_bit=%0b out_last=%0b", pops_b, b_out_bit, b_out_last);
      end
    end
  endtask

  task automatic send(input int sel, input logic [5:0] msg, input string exp_s);
    int n = 0;
    while (((sel == 1) ? b_in_ready : a_in_ready) !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL in_ready_wait: got 0, expected 1 within 50 cycles");
    end
    if (sel == 1) begin b_in_msg = msg; b_in_valid = 1'b1; end
    else          begin a_in_msg = msg; a_in_valid = 1'b1; end
    push_exp(sel, exp_s);
    @(posedge clk); #1;
    // Payload changes after acceptance must not disturb the frame.
    if (sel == 1) begin b_in_valid = 1'b0; b_in_msg = ~msg; end
    else          begin a_in_valid = 1'b0; a_in_msg = ~msg; end
    check("in_ready_busy", (sel == 1) ? b_in_ready : a_in_ready, 1'b0);
  endtask

  task automatic drain(input int sel);
    int n = 0;
    while (qsize(sel) != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (qsize(sel) != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d bits pending, expected 0", qsize(sel));
      if (sel == 1) qb.delete(); else qa.delete();
    end
    check("in_ready_after_last", (sel == 1) ? b_in_ready : a_in_ready, 1'b1);
    check("out_valid_after_last", (sel == 1) ? b_out_valid : a_out_valid, 1'b0);
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (pops_a < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (pops_a < target) begin
      checks++; errors++;
      $display("FAIL pops_wait: got %0d bits, expected %0d", pops_a, target);
    end
  endtask

  initial begin
    logic hb, hl;
    int   base;
    fork
      monitor();
    join_none

    rst = 1'b1; out_ready = 1'b1;
    a_in_valid = 1'b0; a_in_msg = '0;
    b_in_valid = 1'b0; b_in_msg = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_last", a_out_last, 1'b0);
    check("rst_out_bit", a_out_bit, 1'b0);
    check("rst_b_in_ready", b_in_ready, 1'b1);
    check("rst_b_out_valid", b_out_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single one, then all ones.
    send(0, 6'b000001, a_one);
    drain(0);
    send(0, 6'b111111, a_ones);
    drain(0);

    // Stall for three cycles after the fifth bit.
    base = pops_a;
    send(0, 6'b111111, a_ones);
    wait_pops(base + 5);
    out_ready = 1'b0;
    hb = a_out_bit;
    hl = a_out_last;
    repeat (3) begin
      @(negedge clk); #1;
      check("stall_out_bit", a_out_bit, hb);
      check("stall_out_last", a_out_last, hl);
      check("stall_out_valid", a_out_valid, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(0);

    // Reset during step 3 abandons the frame.
    base = pops_a;
    send(0, 6'b111111, a_ones);
    wait_pops(base + 7);
    rst = 1'b1;
    qa.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", a_out_valid, 1'b0);
    check("midrst_in_ready", a_in_ready, 1'b1);
    send(0, 6'b000001, a_one);
    drain(0);

    // K=3 instance.
    send(1, 6'b000001, b_one);
    drain(1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
